// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: channel output modes
// and the counter-width helper used by the debounce and repeat counters.
package btn_pkg;

    localparam logic [1:0] BTN_MODE_LEVEL  = 2'b00;
    localparam logic [1:0] BTN_MODE_PULSE  = 2'b01;
    localparam logic [1:0] BTN_MODE_LATCH  = 2'b10;
    localparam logic [1:0] BTN_MODE_TOGGLE = 2'b11;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, cycle-count debounce, press/release
// strobes, clearable latch/toggle hold and the mode output mux.
// Optional auto-repeat of press strobes is built only with BTN_REPEAT_EN.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
`ifdef BTN_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_raw_i,
    input  logic [1:0] mode_i,
    input  logic       clr_i,
    output logic       btn_stable_o,
    output logic       press_pulse_o,
    output logic       release_pulse_o,
    output logic       btn_out_o
);

    localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          stable_prev_q;
    logic          press_q, press_d;
    logic          release_q;
    logic          hold_q, hold_d;
    logic [1:0]    mode_q;
    logic          press_evt, release_evt;
    logic          hold_base;

    assign press_evt   = stable_q & ~stable_prev_q;
    assign release_evt = ~stable_q & stable_prev_q;

    // Debounce: count consecutive cycles the synchronised input disagrees.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Held state: clear is applied before the press so both together leave 1.
    always_comb begin
        hold_base = clr_i ? 1'b0 : hold_q;
        case (mode_i)
            BTN_MODE_LATCH:  hold_d = hold_base | press_evt;
            BTN_MODE_TOGGLE: hold_d = press_evt ? ~hold_base : hold_base;
            default:         hold_d = 1'b0;
        endcase
    end

`ifdef BTN_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = cnt_width(RPT_MAX);
    localparam logic [RW-1:0] RPT_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_PERIOD = RW'(REPEAT_PERIOD);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_per_q, rpt_per_d;
    logic          rpt_fire;

    // Auto-repeat: zero = idle, otherwise cycles since the last press strobe.
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        rpt_per_d = rpt_per_q;
        rpt_fire  = 1'b0;
        if (!stable_q || !stable_d) begin
            rpt_cnt_d = '0;
            rpt_per_d = 1'b0;
        end else if (press_evt) begin
            rpt_cnt_d = RW'(1);
            rpt_per_d = 1'b0;
        end else if (rpt_cnt_q != '0) begin
            if (rpt_cnt_q == (rpt_per_q ? RPT_PERIOD : RPT_DELAY)) begin
                rpt_fire  = 1'b1;
                rpt_cnt_d = RW'(1);
                rpt_per_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RW'(1);
            end
        end
    end

    assign press_d = press_evt | rpt_fire;

    // Repeat counter state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rpt_cnt_q <= '0;
            rpt_per_q <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_per_q <= rpt_per_d;
        end
    end
`else
    assign press_d = press_evt;
`endif

    // Synchroniser, debounce, strobe and hold registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q       <= 1'b0;
            sync_q        <= 1'b0;
            cnt_q         <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            hold_q        <= 1'b0;
            mode_q        <= BTN_MODE_LEVEL;
        end else begin
            sync1_q       <= btn_raw_i;
            sync_q        <= sync1_q;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= press_d;
            release_q     <= release_evt;
            hold_q        <= hold_d;
            mode_q        <= mode_i;
        end
    end

    // Output select from registered signals only.
    always_comb begin
        case (mode_q)
            BTN_MODE_LEVEL: btn_out_o = stable_q;
            BTN_MODE_PULSE: btn_out_o = press_q;
            default:        btn_out_o = hold_q;
        endcase
    end

    assign btn_stable_o    = stable_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: one btn_channel per button, with the
// 2-bit mode field of each channel sliced from the packed mode bus.
// Auto-repeat of press strobes is compiled in only when BTN_REPEAT_EN is defined.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic                 basys_clk,
    input  logic                 reset,
    input  logic [N_BTN-1:0]     btn_raw,
    input  logic [2*N_BTN-1:0]   mode,
    input  logic [N_BTN-1:0]     clr,
    output logic [N_BTN-1:0]     btn_stable,
    output logic [N_BTN-1:0]     press_pulse,
    output logic [N_BTN-1:0]     release_pulse,
    output logic [N_BTN-1:0]     btn_out
);

`ifndef BTN_REPEAT_EN
    // Repeat timing is part of the interface but has no logic when repeat is off.
    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_rpt_cfg_unused
    end
`endif

    // Independent channels.
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk_i           (basys_clk),
            .rst_i           (reset),
            .btn_raw_i       (btn_raw[i]),
            .mode_i          (mode[2*i +: 2]),
            .clr_i           (clr[i]),
            .btn_stable_o    (btn_stable[i]),
            .press_pulse_o   (press_pulse[i]),
            .release_pulse_o (release_pulse[i]),
            .btn_out_o       (btn_out[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: strobe scoreboard plus per-scenario level checks.
module tb_btn_conditioner;

    localparam int unsigned NB = 2;
    localparam int unsigned DB = 4;
    localparam int          RD = 8;
    localparam int          RP = 3;
`ifdef BTN_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic            basys_clk = 1'b0;
    logic            reset;
    logic [NB-1:0]   btn_raw;
    logic [2*NB-1:0] mode;
    logic [NB-1:0]   clr;
    logic [NB-1:0]   btn_stable, press_pulse, release_pulse, btn_out;

    btn_conditioner #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .basys_clk     (basys_clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .mode          (mode),
        .clr           (clr),
        .btn_stable    (btn_stable),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .btn_out       (btn_out)
    );

    always #5 basys_clk = ~basys_clk;

    int cyc = 0;
    always @(posedge basys_clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int kind;   // 0 press, 1 release
        int ch;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    task automatic push_exp(input int c, input int kind, input int ch);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.ch   = ch;
        exp_q.push_back(e);
    endtask

    // Expected auto-repeat strobes between acceptance edge and falling edge of btn_stable.
    task automatic push_repeats(input int ch, input int t_acc, input int t_fall);
        int e;
        e = t_acc + RD;
        if (RPT_EN) begin
            while (e < t_fall) begin
                push_exp(e, 0, ch);
                e = e + RP;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge basys_clk);
    endtask

    // Scoreboard: every observed strobe must match a pending expectation at this cycle.
    always @(negedge basys_clk) begin
        if (mon_en) begin
            for (int ch = 0; ch < int'(NB); ch++) begin
                for (int kind = 0; kind < 2; kind++) begin
                    logic s;
                    int   idx;
                    s = (kind == 0) ? press_pulse[ch] : release_pulse[ch];
                    if (s === 1'b1) begin
                        idx = -1;
                        for (int k = 0; k < exp_q.size(); k++) begin
                            if (idx < 0 && exp_q[k].kind == kind && exp_q[k].ch == ch && exp_q[k].cyc == cyc)
                                idx = k;
                        end
                        total++;
                        if (idx >= 0) begin
                            exp_q.delete(idx);
                        end else begin
                            bad++;
                            $display("FAIL strobe_%s ch%0d cyc=%0d: observed 1, expected no strobe here",
                                     (kind == 0) ? "press" : "release", ch, cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset   = 1'b1;
        btn_raw = '0;
        mode    = '0;
        clr     = '0;
        tick(2);
        total++;
        if ({btn_stable, press_pulse, release_pulse, btn_out} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 00",
                     {btn_stable, press_pulse, release_pulse, btn_out});
        end
        reset = 1'b0;
        tick(2);
        mon_en = 1'b1;
    endtask

    task automatic test_level();
        int  c;
        logic exp_s;
        mode[1:0] = 2'b00;
        c = cyc;
        btn_raw[0] = 1'b1;
        push_exp(c + 7, 0, 0);
        push_repeats(0, c + 7, c + 26);
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            exp_s = (k >= 6);
            total++;
            if (btn_stable[0] !== exp_s) begin
                bad++;
                $display("FAIL level_stable k=%0d: got %b expected %b", k, btn_stable[0], exp_s);
            end
            total++;
            if (btn_out[0] !== exp_s) begin
                bad++;
                $display("FAIL level_out k=%0d: got %b expected %b", k, btn_out[0], exp_s);
            end
        end
        c = cyc;
        btn_raw[0] = 1'b0;
        push_exp(c + 7, 1, 0);
        tick(10);
        total++;
        if (btn_stable[0] !== 1'b0) begin
            bad++;
            $display("FAIL level_release: got %b expected 0", btn_stable[0]);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL level_pending: got %0d pending strobes expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 4; r++) begin
            btn_raw[0] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick(1);
                total++;
                if (btn_stable[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL glitch_stable r=%0d k=%0d: got %b expected 0", r, k, btn_stable[0]);
                end
            end
            btn_raw[0] = 1'b0;
            tick(1);
        end
        tick(8);
        total++;
        if (btn_stable[0] !== 1'b0) begin
            bad++;
            $display("FAIL glitch_final: got %b expected 0", btn_stable[0]);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL glitch_pending: got %0d pending strobes expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_toggle();
        int   c;
        logic exp_h;
        mode[3:2] = 2'b11;
        tick(1);
        for (int p = 0; p < 3; p++) begin
            c = cyc;
            btn_raw[1] = 1'b1;
            push_exp(c + 7, 0, 1);
            push_repeats(1, c + 7, c + 16);
            tick(10);
            exp_h = (p % 2 == 0);
            total++;
            if (btn_out[1] !== exp_h) begin
                bad++;
                $display("FAIL toggle_press p=%0d: got %b expected %b", p, btn_out[1], exp_h);
            end
            c = cyc;
            btn_raw[1] = 1'b0;
            push_exp(c + 7, 1, 1);
            tick(10);
            total++;
            if (btn_out[1] !== exp_h) begin
                bad++;
                $display("FAIL toggle_release p=%0d: got %b expected %b", p, btn_out[1], exp_h);
            end
        end
        clr[1] = 1'b1;
        tick(1);
        clr[1] = 1'b0;
        total++;
        if (btn_out[1] !== 1'b0) begin
            bad++;
            $display("FAIL toggle_clr: got %b expected 0", btn_out[1]);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL toggle_pending: got %0d pending strobes expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_clr_press();
        int c;
        mode[1:0] = 2'b10;
        tick(1);
        c = cyc;
        btn_raw[0] = 1'b1;
        push_exp(c + 7, 0, 0);
        push_repeats(0, c + 7, c + 16);
        tick(6);
        total++;
        if ({btn_stable[0], press_pulse[0]} !== 2'b10) begin
            bad++;
            $display("FAIL clrpress_accept: got stable,press=%b expected 10", {btn_stable[0], press_pulse[0]});
        end
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        total++;
        if (btn_out[0] !== 1'b1) begin
            bad++;
            $display("FAIL clrpress_same_cycle: got %b expected 1", btn_out[0]);
        end
        tick(3);
        btn_raw[0] = 1'b0;
        push_exp(c + 17, 1, 0);
        tick(10);
        total++;
        if (btn_out[0] !== 1'b1) begin
            bad++;
            $display("FAIL clrpress_latched: got %b expected 1", btn_out[0]);
        end
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        total++;
        if (btn_out[0] !== 1'b0) begin
            bad++;
            $display("FAIL clrpress_clr_alone: got %b expected 0", btn_out[0]);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL clrpress_pending: got %0d pending strobes expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int   r;
        logic exp_s;
        mode[1:0] = 2'b00;
        tick(1);
        btn_raw[0] = 1'b1;
        tick(4);
        reset = 1'b1;
        #1;
        total++;
        if ({btn_stable, press_pulse, release_pulse, btn_out} !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_assert: got %h expected 00", {btn_stable, press_pulse, release_pulse, btn_out});
        end
        tick(2);
        reset = 1'b0;
        r = cyc;
        #1;
        total++;
        if ({btn_stable, press_pulse, release_pulse, btn_out} !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_release: got %h expected 00", {btn_stable, press_pulse, release_pulse, btn_out});
        end
        push_exp(r + 7, 0, 0);
        push_repeats(0, r + 7, r + 16);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp_s = (k >= 6);
            total++;
            if (btn_stable[0] !== exp_s) begin
                bad++;
                $display("FAIL rstmid_stable k=%0d: got %b expected %b", k, btn_stable[0], exp_s);
            end
        end
        tick(4);
        btn_raw[0] = 1'b0;
        push_exp(r + 17, 1, 0);
        tick(10);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rstmid_pending: got %0d pending strobes expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int         c;
        logic [1:0] exp_o;
        mode = 4'b0101;
        tick(1);
        c = cyc;
        btn_raw = 2'b11;
        for (int ch = 0; ch < 2; ch++) begin
            push_exp(c + 7, 0, ch);
            push_repeats(ch, c + 7, c + 14);
        end
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp_o = (k == 7) ? 2'b11 : 2'b00;
            total++;
            if (btn_out !== exp_o) begin
                bad++;
                $display("FAIL b2b_out k=%0d: got %b expected %b", k, btn_out, exp_o);
            end
        end
        btn_raw = 2'b00;
        push_exp(c + 15, 1, 0);
        push_exp(c + 15, 1, 1);
        tick(10);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_pending: got %0d pending strobes expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_repeat();
        int   c;
        logic exp_p;
        mode = 4'b0001;
        tick(1);
        c = cyc;
        btn_raw[0] = 1'b1;
        push_exp(c + 7, 0, 0);
        push_repeats(0, c + 7, c + 36);
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            exp_p = (k == 7) || (RPT_EN && k >= 15 && ((k - 15) % 3) == 0);
            total++;
            if (btn_out[0] !== exp_p) begin
                bad++;
                $display("FAIL repeat_out k=%0d: got %b expected %b", k, btn_out[0], exp_p);
            end
        end
        btn_raw[0] = 1'b0;
        push_exp(c + 37, 1, 0);
        tick(14);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL repeat_pending: got %0d pending strobes expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_glitch();
        test_toggle();
        test_clr_press();
        test_reset_mid();
        test_back_to_back();
        test_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
